// File: rtl/fetch_unit.sv
// Fetch unit: I-cache lookup, AHB word refill on miss, FQ_DEPTH-entry fetch queue. A hit pushes two cycles after IDLE.
// One fetch in flight; a fetch starts only when the queue has room, so stall holds the head and throttles fetches.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                FQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_ready,
  input  logic              ic_hit,
  input  logic [31:0]       ic_rdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  input  logic              HRESP,
  input  logic              stall,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr,
  output logic              out_fault
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
  localparam logic [ADDR_W-1:0] RESET_FETCH   = {RESET_PC[ADDR_W-1:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_ADDR   = 2'd2,
    S_DATA   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              fault;
  } fq_entry_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_drop;

  fq_entry_t         r_fq [FQ_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_fq_full;
  logic              w_start_ahb;
  fq_entry_t         w_push_entry;
  fq_entry_t         w_head;
  logic              w_unused_redirect_lsbs;

  assign w_fq_full              = (r_count >= CNT_W'(FQ_DEPTH));
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  // Redirect outranks every push: a completing fetch in the redirect cycle is dropped.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_entry = '{pc: r_fetch_pc, instr: ic_rdata, fault: 1'b0};
    case (r_state)
      S_IDLE: begin
        if (fetch_enable && !w_fq_full) begin
          w_next_state = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (redirect_valid) begin
          w_next_state = S_IDLE;
        end else if (ic_ready) begin
          if (ic_hit) begin
            w_push       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          w_next_state       = S_IDLE;
          w_push             = !r_drop && !redirect_valid;
          w_push_entry.instr = HRDATA;
          w_push_entry.fault = HRESP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_start_ahb = (r_state == S_LOOKUP) && (w_next_state == S_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_FETCH;
      r_haddr    <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      // HADDR is captured once per transfer so a redirect cannot disturb the address phase.
      if (w_start_ahb) begin
        r_haddr <= r_fetch_pc;
      end
      if (w_next_state == S_IDLE) begin
        r_drop <= 1'b0;
      end else if (redirect_valid && ((r_state == S_ADDR) || (r_state == S_DATA))) begin
        r_drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq[r_tail] <= w_push_entry;
    end
  end

  assign w_pop = out_valid && !stall && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign w_head    = r_fq[r_head];
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign out_instr = out_valid ? w_head.instr : '0;
  assign out_fault = out_valid ? w_head.fault : 1'b0;

  assign ic_req  = (r_state == S_LOOKUP);
  assign ic_addr = r_fetch_pc;
  assign HADDR   = r_haddr;
  assign HTRANS  = (r_state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE  = 1'b0;
  assign HSIZE   = 3'b010;

endmodule
